// File: rtl/freq_mode_pkg.sv
// Shared constants and state encoding for the frequency-mode sequencer.
package freq_mode_pkg;

  localparam int NUM_MODES = 4;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_DOUBLE = 2'd1;
  localparam logic [1:0] MODE_SWEEP  = 2'd2;
  localparam logic [1:0] MODE_ROLL   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GUARD = 2'd2
  } seq_state_e;

  function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [1:0] idx);
    return NUM_MODES'(1) << idx;
  endfunction

endpackage

// File: rtl/freq_mode_sequencer_key_debounce.sv
// Synchronises the active-low mode key, debounces it and emits one pulse per press.
module key_debounce
  import freq_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic GCLK,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          key_s1;
  logic          key_s2;
  logic          key_acc;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronised level disagrees with the accepted one.
  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      key_s1  <= 1'b1;
      key_s2  <= 1'b1;
      key_acc <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      press  <= 1'b0;
      if (key_s2 == key_acc) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_acc <= key_s2;
        cnt     <= '0;
        press   <= ~key_s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_mode_sequencer.sv
// Break-before-make sequencer for the four DDS shaping modes: disable, drain, guard, enable.
module freq_mode_sequencer
  import freq_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int GUARD_CYC     = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int DWELL_CYC     = 100_000_000
) (
  input  logic                 GCLK,
  input  logic                 reset,
  input  logic                 MOD_SEL_KEY,
  input  logic                 AUTO_EN,
  input  logic                 HOLD,
  input  logic [NUM_MODES-1:0] DDS_DATA_VALID_IN,
  output logic [NUM_MODES-1:0] MOD_SEL,
  output logic [1:0]           MOD_IDX,
  output logic                 SWITCHING,
  output logic                 MUTE,
  output logic                 TIMEOUT_ERR
);

  localparam int WW = $clog2(DWELL_CYC + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam logic [WW-1:0] DWELL_LAST = WW'(DWELL_CYC - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);

  seq_state_e           state_q, state_d;
  logic [1:0]           next_idx_q, next_idx_d;
  logic [WW-1:0]        dwell_q, dwell_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic [NUM_MODES-1:0] mod_sel_d;
  logic [1:0]           mod_idx_d;
  logic                 switching_d;
  logic                 mute_d;
  logic                 timeout_err_d;
  logic                 press;
  logic                 dwell_hit;
  logic                 adv_req;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key (
    .GCLK (GCLK),
    .reset(reset),
    .key_n(MOD_SEL_KEY),
    .press(press)
  );

  // A simultaneous key press and dwell expiry collapse into one advance.
  assign dwell_hit = (state_q == ST_RUN) && AUTO_EN && (dwell_q == DWELL_LAST);
  assign adv_req   = press | dwell_hit;

  always_comb begin
    state_d       = state_q;
    next_idx_d    = next_idx_q;
    dwell_d       = dwell_q;
    drain_d       = drain_q;
    guard_d       = guard_q;
    mod_sel_d     = MOD_SEL;
    mod_idx_d     = MOD_IDX;
    switching_d   = SWITCHING;
    mute_d        = MUTE;
    timeout_err_d = TIMEOUT_ERR;
    case (state_q)
      ST_RUN: begin
        if (!AUTO_EN) begin
          dwell_d = '0;
        end else if (!HOLD) begin
          dwell_d = dwell_hit ? '0 : dwell_q + 1'b1;
        end
        if (adv_req && !HOLD) begin
          next_idx_d  = MOD_IDX + 2'd1;
          state_d     = ST_DRAIN;
          mod_sel_d   = '0;
          mute_d      = 1'b1;
          switching_d = 1'b1;
          drain_d     = '0;
          dwell_d     = '0;
        end
      end
      ST_DRAIN: begin
        dwell_d = '0;
        if (!DDS_DATA_VALID_IN[MOD_IDX]) begin
          state_d = ST_GUARD;
          guard_d = '0;
        end else if (drain_q == DRAIN_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_GUARD;
          guard_d       = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_GUARD: begin
        dwell_d = '0;
        if (guard_q == GUARD_LAST) begin
          state_d     = ST_RUN;
          mod_idx_d   = next_idx_q;
          mod_sel_d   = mode_onehot(next_idx_q);
          mute_d      = 1'b0;
          switching_d = 1'b0;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge GCLK or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      next_idx_q  <= MODE_SINGLE;
      dwell_q     <= '0;
      drain_q     <= '0;
      guard_q     <= '0;
      MOD_SEL     <= mode_onehot(MODE_SINGLE);
      MOD_IDX     <= MODE_SINGLE;
      SWITCHING   <= 1'b0;
      MUTE        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_idx_q  <= next_idx_d;
      dwell_q     <= dwell_d;
      drain_q     <= drain_d;
      guard_q     <= guard_d;
      MOD_SEL     <= mod_sel_d;
      MOD_IDX     <= mod_idx_d;
      SWITCHING   <= switching_d;
      MUTE        <= mute_d;
      TIMEOUT_ERR <= timeout_err_d;
    end
  end

endmodule
